// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory/peripheral slave port between the
// per-core load/store units; completion or timeout is reported to the winner only.
module dmem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MASTERS-1:0]   m_req,
  input  logic [NUM_MASTERS-1:0]   m_we,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0] m_be,
  output logic [NUM_MASTERS-1:0]   m_ack,
  output logic                     m_err,
  output logic [31:0]              m_rdata,
  output logic                     s_req,
  output logic                     s_we,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_be,
  input  logic                     s_ack,
  input  logic [31:0]              s_rdata
);

  localparam int IDX_W = (NUM_MASTERS > 2) ? 2 : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       lastGrant_q, lastGrant_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   sReq_q, sReq_d;
  logic                   sWe_q, sWe_d;
  logic [31:0]            sAddr_q, sAddr_d;
  logic [31:0]            sWdata_q, sWdata_d;
  logic [3:0]             sBe_q, sBe_d;
  logic [NUM_MASTERS-1:0] mAck_q, mAck_d;
  logic                   mErr_q, mErr_d;
  logic [31:0]            mRdata_q, mRdata_d;

  logic [31:0] addrArr  [NUM_MASTERS];
  logic [31:0] wdataArr [NUM_MASTERS];
  logic [3:0]  beArr    [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : gUnpack
    assign addrArr[g]  = m_addr[32*g +: 32];
    assign wdataArr[g] = m_wdata[32*g +: 32];
    assign beArr[g]    = m_be[4*g +: 4];
  end

  logic             anyReq;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] candIdx;
  int               cand;

  // Walk offsets from farthest to nearest so the closest requester after lastGrant wins.
  always_comb begin
    anyReq  = 1'b0;
    winner  = lastGrant_q;
    candIdx = '0;
    cand    = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = int'(lastGrant_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      candIdx = IDX_W'(cand);
      if (m_req[candIdx]) begin
        anyReq = 1'b1;
        winner = candIdx;
      end
    end
  end

  logic timeoutHit;
  assign timeoutHit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= LAST_IDX;
      cnt_q       <= '0;
      sReq_q      <= 1'b0;
      sWe_q       <= 1'b0;
      sAddr_q     <= '0;
      sWdata_q    <= '0;
      sBe_q       <= '0;
      mAck_q      <= '0;
      mErr_q      <= 1'b0;
      mRdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      sReq_q      <= sReq_d;
      sWe_q       <= sWe_d;
      sAddr_q     <= sAddr_d;
      sWdata_q    <= sWdata_d;
      sBe_q       <= sBe_d;
      mAck_q      <= mAck_d;
      mErr_q      <= mErr_d;
      mRdata_q    <= mRdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = BUSY;
      BUSY:    if (s_ack || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack/err default low so they pulse only for the single RESP cycle.
  always_comb begin
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    sReq_d      = sReq_q;
    sWe_d       = sWe_q;
    sAddr_d     = sAddr_q;
    sWdata_d    = sWdata_q;
    sBe_d       = sBe_q;
    mAck_d      = '0;
    mErr_d      = 1'b0;
    mRdata_d    = mRdata_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          lastGrant_d = winner;
          cnt_d       = '0;
          sReq_d      = 1'b1;
          sWe_d       = m_we[winner];
          sAddr_d     = addrArr[winner];
          sWdata_d    = wdataArr[winner];
          sBe_d       = beArr[winner];
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (s_ack) begin
          mRdata_d            = s_rdata;
          mAck_d[lastGrant_q] = 1'b1;
          sReq_d              = 1'b0;
        end else if (timeoutHit) begin
          mRdata_d            = '0;
          mAck_d[lastGrant_q] = 1'b1;
          mErr_d              = 1'b1;
          sReq_d              = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign s_req   = sReq_q;
  assign s_we    = sWe_q;
  assign s_addr  = sAddr_q;
  assign s_wdata = sWdata_q;
  assign s_be    = sBe_q;
  assign m_ack   = mAck_q;
  assign m_err   = mErr_q;
  assign m_rdata = mRdata_q;

endmodule
